// File: rtl/vga_frame_update_ctrl.sv
// vga_frame_update_ctrl: shadow display registers with round-robin CPU/engine writes, replayed dirty-only at each vblank tick.
// Optional OVERRUN_CNT_EN adds a saturating frame-overrun counter at CPU address 9.
module vga_frame_update_ctrl #(
  parameter int NREGS = 6,
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_chipselect,
  input  logic          a_write,
  input  logic          a_read,
  input  logic [AW-1:0] a_address,
  input  logic [DW-1:0] a_writedata,
  output logic [DW-1:0] a_readdata,
  output logic          a_waitrequest,
  input  logic          b_req,
  input  logic [AW-1:0] b_address,
  input  logic [DW-1:0] b_writedata,
  output logic          b_grant,
  input  logic          frame_tick,
  output logic          d_chipselect,
  output logic          d_write,
  output logic [AW-1:0] d_address,
  output logic [DW-1:0] d_writedata,
  output logic          irq
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t        r_state;
  logic [DW-1:0] r_shadow [NREGS];
  logic [NREGS-1:0] r_dirty;
  logic          r_commit_en, r_irq, r_rr_b, r_d_write;
  logic [AW-1:0] r_idx, r_d_address;
  logic [DW-1:0] r_d_writedata, r_readdata;
  logic          w_a_wr, w_a_reg, w_a_win, w_b_win, w_ctrl_wr, w_wr_en, w_cur_dirty;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] w_wr_data, w_cur_data, w_rd;
`ifdef OVERRUN_CNT_EN
  logic [7:0]    r_ovr;
`endif
  assign w_a_wr    = a_chipselect & a_write;
  assign w_a_reg   = w_a_wr & (a_address < AW'(NREGS));
  // r_rr_b set means the engine won the last tie, so the CPU takes the next one
  assign w_a_win   = w_a_reg & (~b_req | r_rr_b);
  assign w_b_win   = b_req & (~w_a_reg | ~r_rr_b);
  assign w_ctrl_wr = w_a_wr & (a_address == AW'(8));
  assign w_wr_en   = w_a_win | w_b_win;
  assign w_wr_addr = w_a_win ? a_address : b_address;
  assign w_wr_data = w_a_win ? a_writedata : b_writedata;
  assign a_waitrequest = w_a_reg & ~w_a_win;
  assign b_grant       = w_b_win;
  assign a_readdata    = r_readdata;
  assign d_write       = r_d_write;
  assign d_chipselect  = r_d_write;
  assign d_address     = r_d_address;
  assign d_writedata   = r_d_writedata;
  assign irq           = r_irq;
  always_comb begin
    w_cur_dirty = 1'b0;
    w_cur_data  = '0;
    w_rd        = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (r_idx == AW'(i)) {w_cur_dirty, w_cur_data} = {r_dirty[i], r_shadow[i]};
      if (a_address == AW'(i)) w_rd = r_shadow[i];
    end
    if (a_address == AW'(8)) w_rd = DW'({r_state != IDLE, r_commit_en, r_irq});
`ifdef OVERRUN_CNT_EN
    if (a_address == AW'(9)) w_rd = DW'(r_ovr);
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_shadow[i] <= '0;
      r_dirty       <= '0;
      r_commit_en   <= 1'b1;
      r_irq         <= 1'b0;
      r_rr_b        <= 1'b1;
      r_state       <= IDLE;
      r_idx         <= '0;
      r_d_write     <= 1'b0;
      r_d_address   <= '0;
      r_d_writedata <= '0;
      r_readdata    <= '0;
`ifdef OVERRUN_CNT_EN
      r_ovr         <= '0;
`endif
    end else begin
      if (w_a_reg & b_req) r_rr_b <= ~w_a_win;
      // a write landing on the index being scanned keeps it dirty for the next frame
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_en && w_wr_addr == AW'(i)) begin
          r_shadow[i] <= w_wr_data;
          r_dirty[i]  <= 1'b1;
        end else if (r_state == SCAN && r_idx == AW'(i)) r_dirty[i] <= 1'b0;
      end
      if (w_ctrl_wr) r_commit_en <= a_writedata[1];
      if (r_state == DONE) r_irq <= 1'b1;
      else if (w_ctrl_wr && a_writedata[0]) r_irq <= 1'b0;
      if (a_chipselect && a_read) r_readdata <= w_rd;
      r_d_write <= (r_state == SCAN) & w_cur_dirty;
      if (r_state == SCAN && w_cur_dirty) begin
        r_d_address   <= r_idx;
        r_d_writedata <= w_cur_data;
      end
      case (r_state)
        IDLE: if (frame_tick && r_commit_en && |r_dirty) begin
          r_state <= SCAN;
          r_idx   <= '0;
        end
        SCAN: begin
          r_idx   <= r_idx + 1'b1;
          r_state <= (r_idx == AW'(NREGS-1)) ? DONE : SCAN;
        end
        default: r_state <= IDLE;
      endcase
`ifdef OVERRUN_CNT_EN
      if (w_a_wr && a_address == AW'(9)) r_ovr <= '0;
      else if (frame_tick && (r_state != IDLE || (!r_commit_en && |r_dirty)) && r_ovr != 8'hFF)
        r_ovr <= r_ovr + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_vga_frame_update_ctrl.sv
// tb_vga_frame_update_ctrl: directed checks of arbitration, vblank commit, commit gating and reset abort.
module tb_vga_frame_update_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic       a_chipselect = 0, a_write = 0, a_read = 0, a_waitrequest;
  logic [3:0] a_address = 0, b_address = 0, d_address;
  logic [7:0] a_writedata = 0, a_readdata, b_writedata = 0, d_writedata, rd;
  logic       b_req = 0, b_grant, frame_tick = 0, d_chipselect, d_write, irq;
  int         n_tests = 0, n_fail = 0, cyc = 0, t0 = 0;
  logic [3:0] log_a [$];
  logic [7:0] log_d [$];
  logic       log_cs [$];
  int         log_c [$];

  vga_frame_update_ctrl #(.NREGS(6), .AW(4), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .a_chipselect(a_chipselect), .a_write(a_write), .a_read(a_read),
    .a_address(a_address), .a_writedata(a_writedata), .a_readdata(a_readdata),
    .a_waitrequest(a_waitrequest),
    .b_req(b_req), .b_address(b_address), .b_writedata(b_writedata), .b_grant(b_grant),
    .frame_tick(frame_tick),
    .d_chipselect(d_chipselect), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (d_write) begin
    log_a.push_back(d_address);
    log_d.push_back(d_writedata);
    log_cs.push_back(d_chipselect);
    log_c.push_back(cyc - t0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    a_chipselect = 1; a_write = 1; a_address = a; a_writedata = d;
    @(negedge clk);
    a_chipselect = 0; a_write = 0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    a_chipselect = 1; a_read = 1; a_address = a;
    @(negedge clk);
    a_chipselect = 0; a_read = 0;
    d = a_readdata;
  endtask

  task automatic frame_start();
    log_a.delete(); log_d.delete(); log_cs.delete(); log_c.delete();
    @(negedge clk);
    frame_tick = 1; t0 = cyc;
    @(negedge clk);
    frame_tick = 0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    wait_n(3);
    chk("rst_readdata", a_readdata, 0);
    chk("rst_dwrite", d_write, 0);
    chk("rst_dcs", d_chipselect, 0);
    chk("rst_irq", irq, 0);
    chk("rst_wait", a_waitrequest, 0);
    chk("rst_grant", b_grant, 0);
    reset = 0;
    cpu_rd(4'd8, rd); chk("rst_stat", rd, 8'h02);

    // basic commit: two dirty registers
    cpu_wr(4'd0, 8'h14);
    cpu_wr(4'd3, 8'h50);
    frame_start(); wait_n(10);
    chk("c1_count", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("c1_a0", log_a[0], 0); chk("c1_d0", log_d[0], 8'h14); chk("c1_t0", log_c[0], 2);
      chk("c1_cs0", log_cs[0], 1);
      chk("c1_a1", log_a[1], 3); chk("c1_d1", log_d[1], 8'h50); chk("c1_t1", log_c[1], 5);
    end
    chk("c1_irq", irq, 1);
    cpu_rd(4'd8, rd); chk("c1_stat", rd, 8'h03);
    cpu_wr(4'd8, 8'h03);
    chk("c1_irq_clr", irq, 0);

    // arbitration: first tie to CPU, second tie to engine
    @(negedge clk);
    a_chipselect = 1; a_write = 1; a_address = 2; a_writedata = 8'hA2;
    b_req = 1; b_address = 4; b_writedata = 8'hB4;
    #1 chk("arb1_wait", a_waitrequest, 0); chk("arb1_grant", b_grant, 0);
    @(negedge clk);
    a_chipselect = 0; a_write = 0;
    #1 chk("arb2_grant", b_grant, 1);
    @(negedge clk);
    a_chipselect = 1; a_write = 1; a_address = 2; a_writedata = 8'hA3;
    b_req = 1; b_address = 5; b_writedata = 8'hB5;
    #1 chk("arb3_wait", a_waitrequest, 1); chk("arb3_grant", b_grant, 1);
    @(negedge clk);
    b_req = 0;
    #1 chk("arb4_wait", a_waitrequest, 0);
    @(negedge clk);
    a_chipselect = 0; a_write = 0;
    cpu_rd(4'd2, rd); chk("arb_r2", rd, 8'hA3);
    cpu_rd(4'd4, rd); chk("arb_r4", rd, 8'hB4);
    cpu_rd(4'd5, rd); chk("arb_r5", rd, 8'hB5);
    frame_start(); wait_n(10);
    chk("c2_count", log_a.size(), 3);
    if (log_a.size() == 3) begin
      chk("c2_a0", log_a[0], 2); chk("c2_d0", log_d[0], 8'hA3);
      chk("c2_a2", log_a[2], 5); chk("c2_d2", log_d[2], 8'hB5);
    end
    cpu_wr(4'd8, 8'h03);

    // engine write collides with the scan of the same index
    cpu_wr(4'd4, 8'h03);
    frame_start(); wait_n(4);
    b_req = 1; b_address = 4; b_writedata = 8'h02;
    #1 chk("col_grant", b_grant, 1);
    @(negedge clk);
    b_req = 0;
    wait_n(6);
    chk("col_count", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("col_a", log_a[0], 4); chk("col_d", log_d[0], 8'h03); chk("col_t", log_c[0], 6);
    end
    chk("col_irq", irq, 1);
    cpu_rd(4'd4, rd); chk("col_r4", rd, 8'h02);
    cpu_wr(4'd8, 8'h03);
    frame_start(); wait_n(10);
    chk("col2_count", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("col2_a", log_a[0], 4); chk("col2_d", log_d[0], 8'h02);
    end

    // commit disabled keeps dirty bits until re-enabled
    cpu_wr(4'd8, 8'h01);
    cpu_wr(4'd1, 8'h11);
    frame_start(); wait_n(10);
    chk("dis_count", log_a.size(), 0);
    chk("dis_irq", irq, 0);
    cpu_rd(4'd8, rd); chk("dis_stat", rd, 8'h00);
    cpu_wr(4'd8, 8'h02);
    frame_start(); wait_n(10);
    chk("en_count", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("en_a", log_a[0], 1); chk("en_d", log_d[0], 8'h11);
    end
    chk("en_irq", irq, 1);

    // engine writes beyond the bank are granted and dropped; unmapped reads return 0
    @(negedge clk);
    b_req = 1; b_address = 6; b_writedata = 8'h77;
    #1 chk("oob_grant", b_grant, 1);
    @(negedge clk);
    b_req = 0;
    cpu_rd(4'd6, rd); chk("oob_r6", rd, 0);
    cpu_wr(4'd7, 8'h99);
    cpu_rd(4'd7, rd); chk("oob_r7", rd, 0);

    // reset mid-scan
    cpu_wr(4'd8, 8'h03);
    for (int i = 0; i < 4; i++) cpu_wr(4'(i), 8'h20 + 8'(i));
    frame_start(); wait_n(2);
    chk("rs_pre_dwrite", d_write, 1);
    reset = 1;
    #1;
    chk("rs_dwrite", d_write, 0); chk("rs_dcs", d_chipselect, 0);
    chk("rs_daddr", d_address, 0); chk("rs_ddata", d_writedata, 0);
    chk("rs_irq", irq, 0); chk("rs_rdata", a_readdata, 0);
    @(negedge clk);
    reset = 0;
    frame_start(); wait_n(10);
    chk("rs_count", log_a.size(), 0);
    cpu_rd(4'd8, rd); chk("rs_stat", rd, 8'h02);
    cpu_rd(4'd0, rd); chk("rs_r0", rd, 0);

`ifdef OVERRUN_CNT_EN
    cpu_wr(4'd8, 8'h00);
    cpu_wr(4'd0, 8'h05);
    repeat (300) frame_start();
    cpu_rd(4'd9, rd); chk("ovr_sat", rd, 8'hFF);
    cpu_wr(4'd9, 8'h00);
    cpu_rd(4'd9, rd); chk("ovr_clr", rd, 8'h00);
`else
    cpu_wr(4'd9, 8'h55);
    cpu_rd(4'd9, rd); chk("a9_unmapped", rd, 8'h00);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
